// File: rtl/tftp_rx_pkg.sv
// Shared constants and state encoding for the TFTP receive path.
package tftp_rx_pkg;

  localparam logic [15:0] OP_RRQ   = 16'd1;
  localparam logic [15:0] OP_WRQ   = 16'd2;
  localparam logic [15:0] OP_DATA  = 16'd3;
  localparam logic [15:0] OP_ACK   = 16'd4;
  localparam logic [15:0] OP_ERROR = 16'd5;

  localparam int unsigned TFTP_MAX_PAYLOAD = 512;

  typedef enum logic [2:0] {
    StIdle,
    StOpLo,
    StBlkHi,
    StBlkLo,
    StPayload,
    StDrain
  } rx_state_e;

endpackage

// File: rtl/tftp_rx_field_seq.sv
// TFTP receive field sequencer: decodes the opcode, emits block-number and payload
// enables aligned with a registered copy of the byte, and reports packet completion.
module tftp_rx_field_seq
  import tftp_rx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = TFTP_MAX_PAYLOAD,
  parameter int unsigned COUNT_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic               rx_sof,
  input  logic               rx_eof,
  input  logic [7:0]         rx_data,
  output logic [7:0]         eth_data,
  output logic               blockno_en,
  output logic               data_en,
  output logic [15:0]        opcode,
  output logic               is_data,
  output logic               is_ack,
  output logic [COUNT_W-1:0] data_count,
  output logic               pkt_done,
  output logic               pkt_last,
  output logic               pkt_err,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] MaxCount = COUNT_W'(MAX_PAYLOAD);

  rx_state_e          state_q, state_d;
  logic [7:0]         eth_data_q, eth_data_d;
  logic [15:0]        opcode_q, opcode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               drain_err_q, drain_err_d;  // DRAIN ends in pkt_err rather than pkt_done
  logic               blockno_en_q, blockno_en_d;
  logic               data_en_q, data_en_d;
  logic               pkt_done_q, pkt_done_d;
  logic               pkt_last_q, pkt_last_d;
  logic               pkt_err_q, pkt_err_d;

  logic               end_ok;     // eof on this byte would end the packet cleanly
  logic               last_cand;  // clean end here would be the final (short) DATA block
  logic [15:0]        op_full;    // opcode as it completes with the current low byte

  // Next-state, field enables and end-of-packet pulses.
  always_comb begin
    state_d      = state_q;
    eth_data_d   = eth_data_q;
    opcode_d     = opcode_q;
    count_d      = count_q;
    drain_err_d  = drain_err_q;
    blockno_en_d = 1'b0;
    data_en_d    = 1'b0;
    pkt_done_d   = 1'b0;
    pkt_last_d   = 1'b0;
    pkt_err_d    = 1'b0;
    end_ok       = 1'b0;
    last_cand    = 1'b0;
    op_full      = {opcode_q[15:8], rx_data};

    if (rx_valid) begin
      eth_data_d = rx_data;
      if (rx_sof) begin
        // A start while busy aborts the packet in flight; this byte starts a new one.
        pkt_err_d       = (state_q != StIdle);
        opcode_d[15:8]  = rx_data;
        count_d         = '0;
        drain_err_d     = 1'b0;
        if (rx_eof) begin
          pkt_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StOpLo;
        end
      end else if (state_q != StIdle) begin
        unique case (state_q)
          StOpLo: begin
            opcode_d[7:0] = rx_data;
            if (op_full == OP_DATA || op_full == OP_ACK) begin
              state_d = StBlkHi;
            end else begin
              state_d     = StDrain;
              drain_err_d = (op_full != OP_ERROR);
              end_ok      = (op_full == OP_ERROR);
            end
          end
          StBlkHi: begin
            blockno_en_d = 1'b1;
            state_d      = StBlkLo;
          end
          StBlkLo: begin
            blockno_en_d = 1'b1;
            end_ok       = 1'b1;
            if (opcode_q == OP_DATA) begin
              state_d   = StPayload;
              last_cand = 1'b1;
            end else begin
              // Any byte after an ACK's block number is surplus.
              state_d     = StDrain;
              drain_err_d = 1'b1;
            end
          end
          StPayload: begin
            if (count_q < MaxCount) begin
              data_en_d = 1'b1;
              count_d   = count_q + 1'b1;
              end_ok    = 1'b1;
              last_cand = (count_d < MaxCount);
            end else begin
              state_d     = StDrain;
              drain_err_d = 1'b1;
            end
          end
          StDrain: begin
            end_ok = !drain_err_q;
          end
          default: state_d = StIdle;
        endcase

        if (rx_eof) begin
          state_d = StIdle;
          if (end_ok) begin
            pkt_done_d = 1'b1;
            pkt_last_d = last_cand;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      eth_data_q   <= '0;
      opcode_q     <= '0;
      count_q      <= '0;
      drain_err_q  <= 1'b0;
      blockno_en_q <= 1'b0;
      data_en_q    <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_last_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      eth_data_q   <= eth_data_d;
      opcode_q     <= opcode_d;
      count_q      <= count_d;
      drain_err_q  <= drain_err_d;
      blockno_en_q <= blockno_en_d;
      data_en_q    <= data_en_d;
      pkt_done_q   <= pkt_done_d;
      pkt_last_q   <= pkt_last_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  assign eth_data   = eth_data_q;
  assign blockno_en = blockno_en_q;
  assign data_en    = data_en_q;
  assign opcode     = opcode_q;
  assign is_data    = (opcode_q == OP_DATA);
  assign is_ack     = (opcode_q == OP_ACK);
  assign data_count = count_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_last   = pkt_last_q;
  assign pkt_err    = pkt_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tftp_rx_field_seq.sv
// Randomized self-checking bench for tftp_rx_field_seq against a per-packet byte-position model.
module tb_tftp_rx_field_seq;
  import tftp_rx_pkg::*;

  localparam int unsigned MaxPay = 512;
  localparam int unsigned CntW   = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rx_valid = 1'b0;
  logic            rx_sof = 1'b0;
  logic            rx_eof = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic [7:0]      eth_data;
  logic            blockno_en;
  logic            data_en;
  logic [15:0]     opcode;
  logic            is_data;
  logic            is_ack;
  logic [CntW-1:0] data_count;
  logic            pkt_done;
  logic            pkt_last;
  logic            pkt_err;
  logic            busy;

  tftp_rx_field_seq #(
    .MAX_PAYLOAD(MaxPay),
    .COUNT_W    (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_data   (rx_data),
    .eth_data  (eth_data),
    .blockno_en(blockno_en),
    .data_en   (data_en),
    .opcode    (opcode),
    .is_data   (is_data),
    .is_ack    (is_ack),
    .data_count(data_count),
    .pkt_done  (pkt_done),
    .pkt_last  (pkt_last),
    .pkt_err   (pkt_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: position of the next byte inside the current packet.
  bit          in_pkt = 1'b0;
  int          idx = 0;
  logic [15:0] m_op = 16'h0;
  int          m_cnt = 0;

  logic [7:0]  pkt_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Outcome of a complete packet of n bytes: 0 = error, 1 = done, 2 = done + last.
  function automatic int pkt_result(input int n, input logic [15:0] op);
    int p;
    if (n < 2) return 0;
    if (n == 2) return (op == OP_ERROR) ? 1 : 0;
    case (op)
      OP_DATA: begin
        if (n < 4) return 0;
        p = n - 4;
        if (p > MaxPay) return 0;
        return (p < MaxPay) ? 2 : 1;
      end
      OP_ACK:   return (n == 4) ? 1 : 0;
      OP_ERROR: return 1;
      default:  return 0;
    endcase
  endfunction

  task automatic check_outs(input bit blk, input bit dat, input bit done, input bit last,
                            input bit err, input logic [7:0] b);
    check("blockno_en", 32'(blockno_en), 32'(blk));
    check("data_en", 32'(data_en), 32'(dat));
    check("pkt_done", 32'(pkt_done), 32'(done));
    check("pkt_last", 32'(pkt_last), 32'(last));
    check("pkt_err", 32'(pkt_err), 32'(err));
    check("busy", 32'(busy), 32'(in_pkt));
    check("opcode", 32'(opcode), 32'(m_op));
    check("data_count", 32'(data_count), 32'(m_cnt));
    check("is_data", 32'(is_data), 32'(m_op == 16'd3));
    check("is_ack", 32'(is_ack), 32'(m_op == 16'd4));
    if (blk || dat) check("eth_data", 32'(eth_data), 32'(b));
  endtask

  task automatic send(input logic [7:0] b, input bit sof, input bit eof);
    bit blk = 0, dat = 0, done = 0, last = 0, err = 0;
    int r;
    if (sof) begin
      if (in_pkt) err = 1;
      in_pkt = 1;
      idx = 0;
      m_op[15:8] = b;
      m_cnt = 0;
    end else if (in_pkt) begin
      idx++;
    end
    if (in_pkt) begin
      if (idx == 1) m_op[7:0] = b;
      if ((idx == 2 || idx == 3) && (m_op == 16'd3 || m_op == 16'd4)) blk = 1;
      if (m_op == 16'd3 && idx >= 4 && idx < 4 + int'(MaxPay)) begin
        dat = 1;
        m_cnt = idx - 3;
      end
      if (eof) begin
        r = pkt_result(idx + 1, m_op);
        if (r == 0) err = 1;
        else begin
          done = 1;
          last = (r == 2);
        end
        in_pkt = 0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    rx_sof   = sof;
    rx_eof   = eof;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check_outs(blk, dat, done, last, err, b);
  endtask

  task automatic gap();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    rx_sof   = 1'($urandom);
    rx_eof   = 1'($urandom);
    @(posedge clk);
    #1;
    check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Send pkt_q with optional random idle gaps; without eof the packet is left hanging.
  task automatic send_pkt(input bit with_eof, input int gap_pct);
    for (int i = 0; i < pkt_q.size(); i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) gap();
      send(pkt_q[i], i == 0, with_eof && (i == pkt_q.size() - 1));
    end
  endtask

  task automatic mk(input logic [15:0] op, input int extra);
    pkt_q.delete();
    pkt_q.push_back(op[15:8]);
    pkt_q.push_back(op[7:0]);
    for (int i = 0; i < extra; i++) pkt_q.push_back(8'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eth_data"}, 32'(eth_data), 32'h0);
    check({tag, "_opcode"}, 32'(opcode), 32'h0);
    check({tag, "_data_count"}, 32'(data_count), 32'h0);
    check({tag, "_flags"}, 32'({blockno_en, data_en, pkt_done, pkt_last, pkt_err, busy}), 32'h0);
  endtask

  initial begin
    int kind, len;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");

    // DATA block 1, four payload bytes.
    pkt_q = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(1'b1, 0);
    check("data4_count", 32'(data_count), 32'd4);

    // Full-size block, then one byte too many.
    mk(OP_DATA, 2 + MaxPay);
    send_pkt(1'b1, 0);
    mk(OP_DATA, 2 + MaxPay + 1);
    send_pkt(1'b1, 0);

    // ACK, then ACK with a surplus byte.
    pkt_q = '{8'h00, 8'h04, 8'h12, 8'h34};
    send_pkt(1'b1, 0);
    pkt_q = '{8'h00, 8'h04, 8'h12, 8'h34, 8'h56};
    send_pkt(1'b1, 0);

    // Unknown opcode, then ERROR with a message.
    pkt_q = '{8'h00, 8'h07, 8'h11, 8'h22};
    send_pkt(1'b1, 0);
    pkt_q = '{8'h00, 8'h05, 8'h00, 8'h02, 8'h6D, 8'h73, 8'h67, 8'h00};
    send_pkt(1'b1, 0);

    // Runts, zero-payload DATA, and bytes outside any packet.
    pkt_q = '{8'h00, 8'h03, 8'h00};
    send_pkt(1'b1, 0);
    pkt_q = '{8'h00};
    send_pkt(1'b1, 0);
    pkt_q = '{8'h00, 8'h03, 8'h00, 8'h09};
    send_pkt(1'b1, 0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b0);

    // New sof mid-payload, then a clean ACK.
    mk(OP_DATA, 5);
    send_pkt(1'b0, 0);
    pkt_q = '{8'h00, 8'h04, 8'hBE, 8'hEF};
    send_pkt(1'b1, 0);

    // Valid toggling through a DATA packet.
    mk(OP_DATA, 10);
    for (int i = 0; i < pkt_q.size(); i++) begin
      gap();
      send(pkt_q[i], i == 0, i == pkt_q.size() - 1);
    end

    // Reset asserted mid-payload.
    mk(OP_DATA, 8);
    send_pkt(1'b0, 0);
    #2;
    reset = 1'b0;
    in_pkt = 0;
    m_op = 16'h0;
    m_cnt = 0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_hold");
    @(negedge clk);
    reset = 1'b1;

    // Randomized packet mix.
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0, 1: begin
          len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MaxPay - 2, MaxPay + 2))
                                            : int'($urandom_range(0, 30));
          mk(OP_DATA, 2 + len);
        end
        2: mk(OP_ACK, int'($urandom_range(0, 4)));
        3: mk(OP_ERROR, int'($urandom_range(0, 10)));
        4: mk(16'($urandom_range(0, 9)), int'($urandom_range(0, 6)));
        5: mk({8'($urandom), 8'($urandom)}, int'($urandom_range(0, 5)));
        6: begin
          mk(OP_DATA, int'($urandom_range(0, 8)));
          void'(pkt_q.pop_back());
        end
        default: mk(OP_ACK, 2);
      endcase
      send_pkt($urandom_range(0, 5) != 0, int'($urandom_range(0, 40)));
      if (!in_pkt && $urandom_range(0, 3) == 0) send(8'($urandom), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tftp_rx_field_seq.md
# tftp_rx_field_seq

Upstream field sequencer of the TFTP receive path. Consumes the UDP payload byte stream, decodes the 2-byte TFTP opcode, and generates the per-field enables that drive the block-number decoder and the payload sink. Enables are aligned with a registered copy of the byte. It also counts payload length, detects the final (short) DATA block, and flags malformed packets.

## Interface
- MAX_PAYLOAD, default 512: maximum DATA payload bytes; a DATA packet with fewer bytes is the last block.
- COUNT_W, default 10: width of the payload counter; must hold MAX_PAYLOAD.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data holds a valid payload byte this cycle.
- rx_sof  in  1  with rx_valid: byte is the first of a UDP payload.
- rx_eof  in  1  with rx_valid: byte is the last of a UDP payload; may coincide with rx_sof.
- rx_data  in  8  payload byte.
- eth_data  out  8  registered rx_data; valid whenever blockno_en or data_en is high.
- blockno_en  out  1  high for the two block-number bytes, MSB first; drives the downstream block-number decoder.
- data_en  out  1  high for each DATA payload byte.
- opcode  out  16  opcode of the current or last packet; held until the next opcode completes.
- is_data / is_ack  out  1 each  level outputs: opcode == 3 / opcode == 4; valid after OP_LO.
- data_count  out  COUNT_W  payload bytes passed so far in the current packet.
- pkt_done  out  1  one-cycle pulse: packet ended without error.
- pkt_last  out  1  pulses with pkt_done for a DATA packet with data_count < MAX_PAYLOAD.
- pkt_err  out  1  one-cycle pulse: packet aborted as malformed.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, OP_LO, BLK_HI, BLK_LO, PAYLOAD, DRAIN.
- A byte is consumed only when rx_valid = 1. Gaps are allowed in every state; they cause no state change and no enable.
- IDLE: on rx_sof, the byte becomes opcode[15:8] and the state moves to OP_LO. Bytes without rx_sof are ignored.
- OP_LO: the byte becomes opcode[7:0].
  - Opcode 3 (DATA) or 4 (ACK): go to BLK_HI.
  - Opcode 5 (ERROR), or any other opcode: go to DRAIN. No enables are generated. Opcode 5 ends with pkt_done; all other opcodes end with pkt_err.
- BLK_HI, then BLK_LO: blockno_en is asserted for each of the two bytes.
  - After BLK_LO, DATA goes to PAYLOAD and ACK goes to DRAIN.
  - An ACK with extra bytes after BLK_LO raises pkt_err at eof.
- PAYLOAD: data_en is asserted and data_count is incremented for each byte.
  - If byte number MAX_PAYLOAD+1 arrives: no data_en, set the error flag, go to DRAIN.
- rx_eof ends the packet in any non-IDLE state. The state returns to IDLE.
- Runt packet: eof in OP_LO (i.e. on the opcode-high byte), BLK_HI, or BLK_LO gives pkt_err. The byte carrying eof is still processed, including its enable.
- rx_sof while busy: the current packet aborts with pkt_err. That byte is taken as the new opcode[15:8] and the state goes to OP_LO.
- A DATA packet with 0 payload bytes is valid: pkt_done and pkt_last both pulse.
- data_count clears when opcode[15:8] is captured. It saturates at MAX_PAYLOAD.

## Timing
- Reset values: state IDLE, eth_data 0, opcode 0, data_count 0. All enables, pulses and flags are 0.
- Latency is 1 cycle. The byte accepted at edge N appears on eth_data, with its enable, during cycle N+1.
- pkt_done, pkt_last and pkt_err pulse in the cycle after the eof byte (same cycle as that byte's enable) or after the aborting sof byte.
- pkt_done and pkt_err are mutually exclusive.
- Reset asserted mid-packet clears everything immediately. No pulse is emitted.
- Throughput is one byte per cycle, with no backpressure.

## Structure
- Shared package tftp_rx_pkg holds:
  - Opcode constants: OP_RRQ=1, OP_WRQ=2, OP_DATA=3, OP_ACK=4, OP_ERROR=5.
  - TFTP_MAX_PAYLOAD=512.
  - The state encoding.
- No sub-module: single FSM plus counter. The block-number decoder is instantiated beside this block at the rx top level, fed by eth_data and blockno_en.

## Test plan
- DATA, block 1, 4 payload bytes, sequence 00 03 00 01 AA BB CC DD (eof on DD): blockno_en for 00,01; data_en ×4; pkt_done = pkt_last = 1; data_count = 4.
- DATA with 512 payload bytes: pkt_done = 1, pkt_last = 0. Same packet with 513 bytes: 512 data_en, then pkt_err.
- ACK 00 04 12 34: blockno_en for 12,34; no data_en; pkt_done. ACK with a fifth byte: pkt_err.
- Opcode 00 07: no enables; DRAIN until eof; pkt_err. Opcode 00 05 with a message: pkt_done.
- Runt 00 03 00 (eof): pkt_err. A new sof arriving mid-payload: pkt_err, then the new packet decodes correctly.
- rx_valid toggled 1/0 through a DATA packet gives the same enables and counts. reset=0 mid-PAYLOAD: outputs return to 0 next cycle with no pulses.
